// File: rtl/tmds_encoder.sv
// tmds_encoder: DVI 1.0 TMDS encoder for one colour channel.
// Two-stage elastic pipeline. Stage 1 does transition minimisation (q_m).
// Stage 2 does DC balancing and holds the symbol presented to the serializer FIFO.
// The input side uses a valid/ready handshake. The output side uses a write strobe gated by FIFO full.
// DISP_W must be at least 5 so the running disparity (|cnt| <= 10) fits.
module tmds_encoder #(
   parameter int DISP_W = 5
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              pixel_valid_i,
   output logic              pixel_ready_o,
   input  logic              de_i,
   input  logic [7:0]        data_i,
   input  logic [1:0]        ctrl_i,
   input  logic              symbol_fifo_full_i,
   output logic              write_symbol_o,
   output logic [9:0]        symbol_o,
   output logic [DISP_W-1:0] disparity_o
);

   localparam logic signed [DISP_W-1:0] TWO   = DISP_W'(2);
   localparam logic signed [DISP_W-1:0] EIGHT = DISP_W'(8);

   // Stage 1 state
   logic        s1_valid_q, s1_valid_d;
   logic        s1_de_q,    s1_de_d;
   logic [1:0]  s1_ctrl_q,  s1_ctrl_d;
   logic [8:0]  s1_qm_q,    s1_qm_d;

   // Stage 2 state
   logic                     s2_valid_q, s2_valid_d;
   logic [9:0]               symbol_q,   symbol_d;
   logic signed [DISP_W-1:0] cnt_q,      cnt_d;

   logic advance;
   logic accept;

   // Stage 1 combinational results
   logic [3:0] n1_in;
   logic       use_xnor;
   logic [8:0] qm_in;

   // Stage 2 combinational results
   logic [3:0]               n1_qm;
   logic signed [DISP_W-1:0] bal;      // N1 - N0 of q_m[7:0]
   logic                     cnt_zero, cnt_neg, cnt_pos;
   logic                     bal_zero, bal_neg, bal_pos;
   logic [9:0]               sym_new;
   logic signed [DISP_W-1:0] cnt_new;

   // Handshake. The output stage moves whenever it is empty or the FIFO has room.
   assign advance        = s2_valid_q ? ~symbol_fifo_full_i : 1'b1;
   assign pixel_ready_o  = ~s1_valid_q | advance;
   assign accept         = pixel_valid_i & pixel_ready_o;
   assign write_symbol_o = s2_valid_q & ~symbol_fifo_full_i;
   assign symbol_o       = symbol_q;
   assign disparity_o    = cnt_q;

   // Transition minimisation. Pick XOR or XNOR so the 8-bit word has fewer transitions.
   always_comb begin
      n1_in = '0;
      for (int i = 0; i < 8; i++) begin
         n1_in = n1_in + {3'b000, data_i[i]};
      end
      use_xnor = (n1_in > 4'd4) | ((n1_in == 4'd4) & ~data_i[0]);
      qm_in    = '0;
      qm_in[0] = data_i[0];
      for (int i = 1; i < 8; i++) begin
         qm_in[i] = use_xnor ? ~(qm_in[i-1] ^ data_i[i]) : (qm_in[i-1] ^ data_i[i]);
      end
      qm_in[8] = ~use_xnor;
   end

   // DC balancing. Choose polarity from the running disparity and compute the new disparity.
   always_comb begin
      n1_qm = '0;
      for (int i = 0; i < 8; i++) begin
         n1_qm = n1_qm + {3'b000, s1_qm_q[i]};
      end
      bal      = ($signed({{(DISP_W-4){1'b0}}, n1_qm}) <<< 1) - EIGHT;
      cnt_zero = (cnt_q == '0);
      cnt_neg  = cnt_q[DISP_W-1];
      cnt_pos  = ~cnt_neg & ~cnt_zero;
      bal_zero = (bal == '0);
      bal_neg  = bal[DISP_W-1];
      bal_pos  = ~bal_neg & ~bal_zero;
      sym_new  = symbol_q;
      cnt_new  = cnt_q;
      if (!s1_de_q) begin
         case (s1_ctrl_q)
            2'b00:   sym_new = 10'h354;
            2'b01:   sym_new = 10'h0AB;
            2'b10:   sym_new = 10'h154;
            default: sym_new = 10'h2AB;
         endcase
         cnt_new = '0;
      end else if (cnt_zero | bal_zero) begin
         sym_new = {~s1_qm_q[8], s1_qm_q[8], s1_qm_q[8] ? s1_qm_q[7:0] : ~s1_qm_q[7:0]};
         cnt_new = s1_qm_q[8] ? (cnt_q + bal) : (cnt_q - bal);
      end else if ((cnt_pos & bal_pos) | (cnt_neg & bal_neg)) begin
         sym_new = {1'b1, s1_qm_q[8], ~s1_qm_q[7:0]};
         cnt_new = cnt_q + (s1_qm_q[8] ? TWO : '0) - bal;
      end else begin
         sym_new = {1'b0, s1_qm_q[8], s1_qm_q[7:0]};
         cnt_new = cnt_q - (s1_qm_q[8] ? '0 : TWO) + bal;
      end
   end

   // Next-state for both pipeline stages.
   // Stage 1 refills on accept. Stage 2 takes stage 1 whenever it advances.
   always_comb begin
      s1_valid_d = accept | (s1_valid_q & ~advance);
      s1_de_d    = s1_de_q;
      s1_ctrl_d  = s1_ctrl_q;
      s1_qm_d    = s1_qm_q;
      if (accept) begin
         s1_de_d   = de_i;
         s1_ctrl_d = ctrl_i;
         s1_qm_d   = qm_in;
      end
      s2_valid_d = advance ? s1_valid_q : s2_valid_q;
      symbol_d   = symbol_q;
      cnt_d      = cnt_q;
      if (advance & s1_valid_q) begin
         symbol_d = sym_new;
         cnt_d    = cnt_new;
      end
   end

   // Pipeline registers. Reset drops any in-flight beats.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_valid_q <= 1'b0;
         s1_de_q    <= 1'b0;
         s1_ctrl_q  <= '0;
         s1_qm_q    <= '0;
         s2_valid_q <= 1'b0;
         symbol_q   <= '0;
         cnt_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_de_q    <= s1_de_d;
         s1_ctrl_q  <= s1_ctrl_d;
         s1_qm_q    <= s1_qm_d;
         s2_valid_q <= s2_valid_d;
         symbol_q   <= symbol_d;
         cnt_q      <= cnt_d;
      end
   end

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder.
// The driver pushes an expected symbol/disparity when each beat is accepted.
// The monitor pops and compares on every FIFO write strobe.
module tb_tmds_encoder;

   localparam int DISP_W = 5;

   logic              clk = 1'b0;
   logic              rst_i;
   logic              pixel_valid_i;
   logic              pixel_ready_o;
   logic              de_i;
   logic [7:0]        data_i;
   logic [1:0]        ctrl_i;
   logic              symbol_fifo_full_i;
   logic              write_symbol_o;
   logic [9:0]        symbol_o;
   logic [DISP_W-1:0] disparity_o;

   typedef struct {
      logic [9:0] sym;
      int         disp;
      bit         de;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests   = 0;
   int   n_fail    = 0;
   int   model_cnt = 0;
   bit   done6     = 1'b0;

   logic [7:0] vec_a [16] = '{8'hFF, 8'h10, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h81, 8'h7E,
                              8'h3C, 8'h01, 8'h80, 8'hC3, 8'h96, 8'h69, 8'hE7, 8'h18};

   always #5 clk = ~clk;

   tmds_encoder #(.DISP_W(DISP_W)) dut (
      .clk_i              (clk),
      .rst_i              (rst_i),
      .pixel_valid_i      (pixel_valid_i),
      .pixel_ready_o      (pixel_ready_o),
      .de_i               (de_i),
      .data_i             (data_i),
      .ctrl_i             (ctrl_i),
      .symbol_fifo_full_i (symbol_fifo_full_i),
      .write_symbol_o     (write_symbol_o),
      .symbol_o           (symbol_o),
      .disparity_o        (disparity_o)
   );

   task automatic check(input string name, input int actual, input int expected);
      n_tests++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, actual, actual, expected, expected);
      end
   endtask

   // Golden DVI 1.0 encoder. Updates the bench's own running disparity.
   function automatic logic [9:0] model_encode(input bit de, input logic [7:0] d,
                                               input logic [1:0] c, inout int cnt);
      logic [8:0] qm;
      logic [9:0] s;
      int ones, zeros, n1;
      if (!de) begin
         cnt = 0;
         case (c)
            2'b00:   return 10'h354;
            2'b01:   return 10'h0AB;
            2'b10:   return 10'h154;
            default: return 10'h2AB;
         endcase
      end
      n1 = $countones(d);
      qm = '0;
      qm[0] = d[0];
      if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
         for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
         qm[8] = 1'b0;
      end else begin
         for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
         qm[8] = 1'b1;
      end
      ones  = $countones(qm[7:0]);
      zeros = 8 - ones;
      if (cnt == 0 || ones == zeros) begin
         s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
         if (qm[8]) cnt = cnt + ones - zeros;
         else       cnt = cnt + zeros - ones;
      end else if ((cnt > 0 && ones > zeros) || (cnt < 0 && zeros > ones)) begin
         s = {1'b1, qm[8], ~qm[7:0]};
         cnt = cnt + (qm[8] ? 2 : 0) + zeros - ones;
      end else begin
         s = {1'b0, qm[8], qm[7:0]};
         cnt = cnt - (qm[8] ? 0 : 2) + ones - zeros;
      end
      return s;
   endfunction

   // Receiver-side decode of a data symbol back to the 8-bit pixel.
   function automatic logic [7:0] decode(input logic [9:0] s);
      logic [7:0] d, o;
      d = s[9] ? ~s[7:0] : s[7:0];
      o[0] = d[0];
      for (int i = 1; i < 8; i++) o[i] = s[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
      return o;
   endfunction

   // Present one beat until it is accepted, then push its expectation.
   task automatic send_beat(input bit de, input logic [7:0] d, input logic [1:0] c,
                            input bit hand, input logic [9:0] hsym, input int hdisp);
      bit r;
      int waited;
      exp_t e;
      logic [9:0] m;
      pixel_valid_i = 1'b1;
      de_i = de;
      data_i = d;
      ctrl_i = c;
      waited = 0;
      forever begin
         @(negedge clk);
         r = pixel_ready_o;
         @(posedge clk);
         if (r) begin
            m = model_encode(de, d, c, model_cnt);
            e.sym  = hand ? hsym : m;
            e.disp = hand ? hdisp : model_cnt;
            e.de   = de;
            e.data = d;
            exp_q.push_back(e);
            break;
         end
         waited++;
         if (waited > 100) begin
            check("accept_timeout", 0, 1);
            break;
         end
      end
      #1 pixel_valid_i = 1'b0;
   endtask

   task automatic drain();
      int waited;
      waited = 0;
      while (exp_q.size() != 0 && waited < 200) begin
         @(posedge clk);
         waited++;
      end
      #1;
      check("drain_queue_empty", exp_q.size(), 0);
   endtask

   // Monitor: compare every write against the scoreboard head.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_i !== 1'b1) begin
            if (symbol_fifo_full_i === 1'b1) check("no_write_while_full", int'(write_symbol_o), 0);
            if (write_symbol_o === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("symbol", int'(symbol_o), int'(e.sym));
                  check("disparity", int'($signed(disparity_o)), e.disp);
                  if (e.de) check("decode", int'(decode(symbol_o)), int'(e.data));
                  $display("[TB] write sym=%03h disp=%0d exp_sym=%03h exp_disp=%0d", symbol_o,
                           $signed(disparity_o), e.sym, e.disp);
               end
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] cap_sym;
      logic [DISP_W-1:0] cap_disp;
      rst_i = 1'b1;
      pixel_valid_i = 1'b0;
      de_i = 1'b0;
      data_i = '0;
      ctrl_i = '0;
      symbol_fifo_full_i = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b0;
      @(negedge clk);
      check("reset_write", int'(write_symbol_o), 0);
      check("reset_symbol", int'(symbol_o), 0);
      check("reset_disp", int'(disparity_o), 0);
      check("reset_ready", int'(pixel_ready_o), 1);
      @(posedge clk);
      #1;

      // 1: two zero pixels
      send_beat(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
      send_beat(1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF, 2);
      // 2: control symbols, disparity forced to zero
      send_beat(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
      send_beat(1'b0, 8'h00, 2'b01, 1'b1, 10'h0AB, 0);
      send_beat(1'b0, 8'h00, 2'b10, 1'b1, 10'h154, 0);
      send_beat(1'b0, 8'h00, 2'b11, 1'b1, 10'h2AB, 0);
      drain();

      // 3: pixel stream against the golden model
      for (int i = 0; i < 16; i++) send_beat(1'b1, vec_a[i], 2'b00, 1'b0, 10'h000, 0);
      drain();

      // 4: five-cycle stall mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++) send_beat(1'b1, vec_a[15-i], 2'b00, 1'b0, 10'h000, 0);
         end
         begin
            repeat (3) @(posedge clk);
            #1 symbol_fifo_full_i = 1'b1;
            for (int k = 0; k < 5; k++) begin
               @(negedge clk);
               check("stall_write", int'(write_symbol_o), 0);
               check("stall_ready", int'(pixel_ready_o), 0);
               if (k == 0) begin
                  cap_sym = symbol_o;
                  cap_disp = disparity_o;
               end else begin
                  check("stall_symbol_hold", int'(symbol_o), int'(cap_sym));
                  check("stall_disp_hold", int'(disparity_o), int'(cap_disp));
               end
               @(posedge clk);
            end
            #1 symbol_fifo_full_i = 1'b0;
         end
      join
      drain();

      // 5: reset with both stages occupied and cnt = +2
      send_beat(1'b0, 8'h00, 2'b00, 1'b1, 10'h354, 0);
      send_beat(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
      send_beat(1'b1, 8'h00, 2'b00, 1'b1, 10'h3FF, 2);
      send_beat(1'b1, 8'h00, 2'b00, 1'b0, 10'h000, 0);
      symbol_fifo_full_i = 1'b1;
      @(negedge clk);
      check("pre_reset_disp", int'($signed(disparity_o)), 2);
      check("pre_reset_ready", int'(pixel_ready_o), 0);
      @(posedge clk);
      #1 rst_i = 1'b1;
      @(posedge clk);
      #1 rst_i = 1'b0;
      symbol_fifo_full_i = 1'b0;
      exp_q.delete();
      model_cnt = 0;
      @(negedge clk);
      check("post_reset_write", int'(write_symbol_o), 0);
      check("post_reset_disp", int'(disparity_o), 0);
      check("post_reset_ready", int'(pixel_ready_o), 1);
      @(posedge clk);
      #1;
      send_beat(1'b1, 8'h00, 2'b00, 1'b1, 10'h100, -8);
      drain();

      // 6: valid toggling with full toggling out of phase
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               send_beat(1'b1, vec_a[(i * 5) % 16], 2'b00, 1'b0, 10'h000, 0);
               @(posedge clk);
               #1;
            end
            done6 = 1'b1;
         end
         begin
            while (!done6) begin
               @(posedge clk);
               #1 symbol_fifo_full_i = ~symbol_fifo_full_i;
            end
            symbol_fifo_full_i = 1'b0;
         end
      join
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
